exam1_result_acc: RTL and testbench
===================================

// Module: exam1_result_acc
// PURPOSE
//  Downstream consumer of the exam1 ALU result stream. Takes the registered 16-bit
//  signed ALU output, one sample per accepted valid/ready beat, and sums WINDOW
//  samples with a saturating add. It also tracks the min and max of the window.
//  It then presents {sum, min, max, sat} on a valid/ready output port and holds it
//  until the port consumes it.
// PARAMETERS
//  WIDTH      16  width of signed input sample (ALU out width = 2*8)
//  ACC_WIDTH  18  width of signed saturating sum
//  WINDOW     8   samples per result; legal range 2..255
// PORTS
//  clk        in   1          single clock; every flop on posedge
//  rst        in   1          synchronous, active-high reset
//  clear      in   1          sync flush of partial window / held result
//  in_valid   in   1          upstream sample valid
//  in_data    in   WIDTH      signed sample (ALU out)
//  in_ready   out  1          block can accept a sample this cycle
//  out_valid  out  1          window result valid
//  out_ready  in   1          downstream takes result this cycle
//  out_sum    out  ACC_WIDTH  signed saturated sum of window
//  out_min    out  WIDTH      signed minimum of window
//  out_max    out  WIDTH      signed maximum of window
//  out_sat    out  1          sum clipped at least once in this window
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=ACC, count=0, acc=0, sat=0, out_valid=0,
//    out_sum=0, out_min=0, out_max=0, out_sat=0. rst overrides clear and all other inputs.
//  - FSM, 2 states:
//    ACC : in_ready=1, out_valid=0. Accept = in_valid&in_ready.
//          On accept with count<WINDOW-1: acc=sat_add(acc,in_data); update min/max;
//          count++.
//          On accept with count==WINDOW-1: load the final sum/min/max/sat into the out_*
//          registers; out_valid=1 next cycle; count=0; acc=0; go to HOLD.
//    HOLD: in_ready=0. The out_* registers are stable while out_valid&!out_ready.
//          On out_ready=1: out_valid=0 next cycle; go to ACC.
//          No same-cycle refill, so each window has a one-cycle bubble.
//  - Latency: out_valid rises on the cycle after the WINDOW-th accept.
//  - First sample of a window (count==0) loads min=max=in_data. It is not compared
//    against stale values.
//  - Saturating add: form the (ACC_WIDTH+1)-bit sum. Clip to +2^(ACC_WIDTH-1)-1 or
//    -2^(ACC_WIDTH-1) and set sat. sat is sticky for the window and cleared when
//    the window starts. in_data is sign-extended to ACC_WIDTH before the add.
//  - clear=1 (rst=0):
//    in ACC: count=0, acc=0, sat=0; the sample on the same cycle is dropped.
//    in HOLD: out_valid=0; the held result is discarded; go to ACC.
//    out_sum/min/max retain their last values (don't-care while out_valid=0).
//  - in_data is ignored when in_valid=0 or in_ready=0. Upstream (the ALU) must hold
//    its sample while in_ready=0.
//  - X/Z on in_data while in_valid=0 must not propagate into any register.
// STRUCTURE
//  - Shared package exam1_pkg: ALU_W=16; FSM encoding ST_ACC=1'b0, ST_HOLD=1'b1;
//    functions sat_max(w) and sat_min(w).
//  - One sub-module: exam1_sat_add. Combinational signed saturating adder
//    (params A_W, S_W), output {sum, ovf}. Instanced once for acc.
//  - The rest (FSM, counter, min/max, output regs) lives in this module.
// TESTING
//  1. rst held 10 cycles with X on in_data -> every output 0 and in_ready=1 after rst
//     falls.
//  2. WINDOW=8, samples 1..8, out_ready=1 -> out_sum=36, min=1, max=8, sat=0.
//     out_valid lasts 1 cycle, on the cycle after the 8th accept.
//  3. 8 samples of 16'sd32767 -> out_sum=131071 (+max), sat=1. Repeat with 16'sh8000
//     -> out_sum=-131072, sat=1.
//  4. Mixed signs -5,3,-128,127,0,0,-1,2 -> sum=-2, min=-128, max=127. Hold out_ready=0
//     for 5 cycles: outputs stable, in_ready=0, in_valid pulses ignored.
//  5. Accept 5 samples, pulse clear with in_valid=1, then feed 8 samples of 2 ->
//     out_sum=16. The clear-cycle sample and pre-clear samples are not counted.
//  6. rst asserted in HOLD, and separately mid-window -> next cycle out_valid=0 and
//     count=0. A fresh window then yields the correct sum.

Source files
------------

// File: rtl/exam1_pkg.sv
// ============================================================================
// Module : exam1_pkg
// Shared types and constants for the exam1 result-accumulator slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exam1_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Saturation limits of a w-bit two's-complement value (w <= 31).
  function automatic logic signed [31:0] sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/exam1_sat_add.sv
// ============================================================================
// Module : exam1_sat_add
// Combinational signed saturating add of an A_W sample onto an S_W sum.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exam1_sat_add
  import exam1_pkg::*;
#(
  parameter int A_W = 16,
  parameter int S_W = 18
) (
  input  logic signed [S_W-1:0] i_a,
  input  logic signed [A_W-1:0] i_b,
  output logic signed [S_W-1:0] o_sum,
  output logic                  o_ovf
);

  localparam logic signed [S_W-1:0] c_MAX = S_W'(sat_max(S_W));
  localparam logic signed [S_W-1:0] c_MIN = S_W'(sat_min(S_W));

  logic signed [S_W:0] w_full;

  // One guard bit: overflow exactly when the two top bits disagree.
  assign w_full = {i_a[S_W-1], i_a} + {{(S_W + 1 - A_W){i_b[A_W-1]}}, i_b};
  assign o_ovf  = w_full[S_W] ^ w_full[S_W-1];

  always_comb begin
    o_sum = w_full[S_W-1:0];
    if (o_ovf) begin
      o_sum = w_full[S_W] ? c_MIN : c_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exam1_result_acc.sv
// ============================================================================
// Module : exam1_result_acc
// Windowed saturating sum / min / max of the ALU result stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exam1_result_acc
  import exam1_pkg::*;
#(
  parameter int WIDTH     = ALU_W,
  parameter int ACC_WIDTH = 18,
  parameter int WINDOW    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_sum,
  output logic signed [WIDTH-1:0]     out_min,
  output logic signed [WIDTH-1:0]     out_max,
  output logic                        out_sat
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WINDOW - 1);

  state_t                      r_state;
  logic [CNT_W-1:0]            r_count;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_sat;
  logic signed [WIDTH-1:0]     r_min;
  logic signed [WIDTH-1:0]     r_max;
  logic                        r_out_valid;
  logic signed [ACC_WIDTH-1:0] r_out_sum;
  logic signed [WIDTH-1:0]     r_out_min;
  logic signed [WIDTH-1:0]     r_out_max;
  logic                        r_out_sat;

  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_ovf;
  logic                        w_first;
  logic signed [WIDTH-1:0]     w_min_nxt;
  logic signed [WIDTH-1:0]     w_max_nxt;

  exam1_sat_add #(
    .A_W (WIDTH),
    .S_W (ACC_WIDTH)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // The first sample of a window seeds min/max rather than comparing to stale values.
  assign w_first   = (r_count == '0);
  assign w_min_nxt = (w_first || (in_data < r_min)) ? in_data : r_min;
  assign w_max_nxt = (w_first || (in_data > r_max)) ? in_data : r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACC;
      r_count     <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_min       <= '0;
      r_max       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (clear) begin
            r_count <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
          end else if (in_valid) begin
            if (r_count == c_LAST) begin
              r_out_sum   <= w_sum;
              r_out_min   <= w_min_nxt;
              r_out_max   <= w_max_nxt;
              r_out_sat   <= r_sat | w_ovf;
              r_out_valid <= 1'b1;
              r_count     <= '0;
              r_acc       <= '0;
              r_sat       <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc   <= w_sum;
              r_sat   <= r_sat | w_ovf;
              r_min   <= w_min_nxt;
              r_max   <= w_max_nxt;
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (clear || out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACC;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_min   = r_out_min;
  assign out_max   = r_out_max;
  assign out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_exam1_result_acc.sv
// ============================================================================
// Module : tb_exam1_result_acc
// Directed plus randomized checking of exam1_result_acc against a window model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exam1_result_acc;

  localparam int WIDTH     = 16;
  localparam int ACC_WIDTH = 18;
  localparam int WINDOW    = 8;
  localparam longint SMAX  = (64'sd1 <<< (ACC_WIDTH - 1)) - 1;
  localparam longint SMIN  = -(64'sd1 <<< (ACC_WIDTH - 1));

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        clear;
  logic                        in_valid;
  logic signed [WIDTH-1:0]     in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic signed [WIDTH-1:0]     out_min;
  logic signed [WIDTH-1:0]     out_max;
  logic                        out_sat;

  exam1_result_acc #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .WINDOW    (WINDOW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_fail = 0;

  // Reference model: accepted samples of the current window plus the held result.
  longint mq[$];
  bit     m_hold = 1'b0;
  longint m_sum = 0, m_min = 0, m_max = 0;
  bit     m_sat = 1'b0;

  longint cap_sum, cap_min, cap_max, cap_sat;
  int     cap_cnt;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_result();
    longint a  = 0;
    longint mn = mq[0];
    longint mx = mq[0];
    bit     s  = 1'b0;
    foreach (mq[i]) begin
      a += mq[i];
      if (a > SMAX) begin a = SMAX; s = 1'b1; end
      else if (a < SMIN) begin a = SMIN; s = 1'b1; end
      if (mq[i] < mn) mn = mq[i];
      if (mq[i] > mx) mx = mq[i];
    end
    m_sum = a; m_min = mn; m_max = mx; m_sat = s;
  endfunction

  // Advance the model with the inputs now applied, clock once, then compare.
  task automatic step();
    if (rst) begin
      mq.delete();
      m_hold = 1'b0;
      m_sum = 0; m_min = 0; m_max = 0; m_sat = 1'b0;
    end else if (!m_hold) begin
      if (clear) mq.delete();
      else if (in_valid) begin
        mq.push_back(longint'(in_data));
        if (mq.size() == WINDOW) begin
          model_result();
          m_hold = 1'b1;
          mq.delete();
        end
      end
    end else if (clear || out_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("in_ready", longint'(in_ready), longint'(!m_hold));
    chk("out_valid", longint'(out_valid), longint'(m_hold));
    chk("out_sum", longint'(out_sum), m_sum);
    chk("out_min", longint'(out_min), m_min);
    chk("out_max", longint'(out_max), m_max);
    chk("out_sat", longint'(out_sat), longint'(m_sat));
    if (out_valid) begin
      cap_sum = longint'(out_sum);
      cap_min = longint'(out_min);
      cap_max = longint'(out_max);
      cap_sat = longint'(out_sat);
      cap_cnt++;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    clear    = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic feed(input longint v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic cap_reset();
    cap_sum = 999999; cap_min = 999999; cap_max = 999999; cap_sat = 9;
    cap_cnt = 0;
  endtask

  initial begin
    longint mixed[8] = '{-5, 3, -128, 127, 0, 0, -1, 2};
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    cap_reset();

    // Reset with undefined sample data.
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    idle(2);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_sum", longint'(out_sum), 0);

    // Ascending window.
    cap_reset();
    for (int i = 1; i <= 8; i++) feed(i);
    chk("t2_valid_next", longint'(out_valid), 1);
    idle(3);
    chk("t2_sum", cap_sum, 36);
    chk("t2_min", cap_min, 1);
    chk("t2_max", cap_max, 8);
    chk("t2_sat", cap_sat, 0);
    chk("t2_one_cycle", longint'(cap_cnt), 1);

    // Positive and negative saturation.
    cap_reset();
    for (int i = 0; i < 8; i++) feed(32767);
    idle(2);
    chk("t3p_sum", cap_sum, 131071);
    chk("t3p_sat", cap_sat, 1);
    cap_reset();
    for (int i = 0; i < 8; i++) feed(-32768);
    idle(2);
    chk("t3n_sum", cap_sum, -131072);
    chk("t3n_sat", cap_sat, 1);

    // Mixed signs with back-pressure; in_valid pulses during HOLD are ignored.
    cap_reset();
    out_ready = 1'b0;
    foreach (mixed[i]) feed(mixed[i]);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 16'sd1000;
      step();
      chk("t4_hold_sum", longint'(out_sum), -2);
      chk("t4_hold_in_ready", longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("t4_min", cap_min, -128);
    chk("t4_max", cap_max, 127);

    // Clear mid-window drops the partial window and the same-cycle sample.
    cap_reset();
    for (int i = 0; i < 5; i++) feed(100);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'sd500;
    step();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) feed(2);
    idle(2);
    chk("t5_sum", cap_sum, 16);

    // Reset in HOLD, then reset mid-window, then a fresh window.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) feed(7);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_hold_rst_valid", longint'(out_valid), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) feed(50);
    rst = 1'b1; step(); rst = 1'b0;
    cap_reset();
    for (int i = 0; i < 8; i++) feed(i - 3);
    idle(2);
    chk("t6_fresh_sum", cap_sum, 4);

    // Randomized traffic with occasional clear, reset and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel       = int'($urandom_range(0, 9));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = (sel == 0) ? 16'sh7fff : (sel == 1) ? 16'sh8000 : WIDTH'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
